// File: rtl/ahb_bram_pkg.sv
// ahb_bram_pkg: AHB transfer/size codes, controller states and byte-lane decode
package ahb_bram_pkg;
    typedef enum logic [1:0] {HT_IDLE, HT_BUSY, HT_NONSEQ, HT_SEQ} htrans_t;
    typedef enum logic [2:0] {SZ_BYTE, SZ_HALF, SZ_WORD} hsize_t;
    typedef enum logic [1:0] {S_IDLE, S_WDATA, S_RDATA, S_STALL} state_t;
    function automatic logic [3:0] lane_mask(input logic [2:0] hsize, input logic [1:0] a);
        return hsize == SZ_BYTE ? 4'b0001 << a : hsize == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction
endpackage

// File: rtl/ahb_bram_lane_dec.sv
// ahb_bram_lane_dec: HSIZE and low address bits to RAM byte-write mask
module ahb_bram_lane_dec import ahb_bram_pkg::*; (
    input  logic [2:0] hsize,
    input  logic [1:0] haddr,
    output logic [3:0] mask
);
    assign mask = lane_mask(hsize, haddr);
endmodule

// File: rtl/ahb_bram_ctrl.sv
// ahb_bram_ctrl: zero-wait AHB-Lite slave driving a dual-port BRAM (write port A, read port B).
// AHB_BRAM_BYPASS_EN forwards write data on read-after-write collisions; otherwise one wait state re-reads.
module ahb_bram_ctrl import ahb_bram_pkg::*; #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDRA,
    output logic [31:0]           BRAM_WDATA,
    output logic [3:0]            BRAM_WEA,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDRB,
    input  logic [31:0]           BRAM_RDATA
);
    state_t state, state_nx;
    logic acc, col, stall_col, unused_bits;
    logic [3:0] mask, wmask;
    logic [ADDR_WIDTH-1:0] haddr_w, waddr, raddr;

    ahb_bram_lane_dec u_lane (.hsize(HSIZE), .haddr(HADDR[1:0]), .mask(mask));

    assign acc = HSEL & HTRANS[1] & HREADY;
    assign haddr_w = HADDR[ADDR_WIDTH+1:2];
    assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};
    // The RAM reads before the pending write lands, so a same-word read sees stale data
    assign col = acc & ~HWRITE & (state == S_WDATA) & (haddr_w == waddr) & |wmask;

    always_ff @(posedge clka) begin
        if (rst) begin
            state <= S_IDLE;
            waddr <= '0;
            wmask <= '0;
            raddr <= '0;
        end else begin
            state <= state_nx;
            if (acc & HWRITE) begin
                waddr <= haddr_w;
                wmask <= mask;
            end
            if (acc & ~HWRITE) raddr <= haddr_w;
        end
    end

    always_comb begin
        state_nx = state == S_STALL ? S_RDATA : !acc ? S_IDLE : HWRITE ? S_WDATA : stall_col ? S_STALL : S_RDATA;
    end

    assign HRESP = 1'b0;
    assign HREADYOUT = state != S_STALL;
    assign BRAM_ADDRA = waddr;
    assign BRAM_WDATA = HWDATA;
    assign BRAM_WEA = state == S_WDATA ? wmask : 4'b0000;
    assign BRAM_ADDRB = state == S_STALL ? raddr : haddr_w;

`ifdef AHB_BRAM_BYPASS_EN
    logic hit;
    logic [3:0] fmask;
    logic [31:0] fdata, fbits;

    always_ff @(posedge clka) begin
        if (rst) begin
            hit <= 1'b0;
            fmask <= '0;
            fdata <= '0;
        end else if (acc & ~HWRITE) begin
            hit <= col;
            fmask <= wmask;
            fdata <= HWDATA;
        end
    end

    assign stall_col = 1'b0;
    assign fbits = {{8{fmask[3]}}, {8{fmask[2]}}, {8{fmask[1]}}, {8{fmask[0]}}};
    assign HRDATA = (hit && state == S_RDATA) ? (fdata & fbits) | (BRAM_RDATA & ~fbits) : BRAM_RDATA;
`else
    assign stall_col = col;
    assign HRDATA = BRAM_RDATA;
`endif
endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// tb_ahb_bram_ctrl: directed and random AHB traffic checked against a word-array memory model
module tb_ahb_bram_ctrl;
    localparam int AW = 14;
    localparam int DEPTH = 1 << AW;

    logic clka = 1'b0, rst = 1'b1;
    logic HSEL = 1'b0, HWRITE = 1'b0, HREADYOUT, HRESP;
    logic [31:0] HADDR = '0, HWDATA = '0, HRDATA, BRAM_WDATA, BRAM_RDATA;
    logic [1:0] HTRANS = 2'd0;
    logic [2:0] HSIZE = 3'd2;
    logic [3:0] BRAM_WEA;
    logic [AW-1:0] BRAM_ADDRA, BRAM_ADDRB;

    logic [31:0] ram [DEPTH];
    logic [31:0] refm [DEPTH];

    int total = 0, bad = 0;
    bit p_valid = 0, p_w = 0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    logic [2:0] p_size = '0;
    int p_exp_wait = 0;

    always #5 clka = ~clka;

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clka(clka), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADYOUT), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .HRDATA(HRDATA), .BRAM_ADDRA(BRAM_ADDRA), .BRAM_WDATA(BRAM_WDATA), .BRAM_WEA(BRAM_WEA),
        .BRAM_ADDRB(BRAM_ADDRB), .BRAM_RDATA(BRAM_RDATA)
    );

    // Read-first block RAM with one cycle of read latency
    always @(posedge clka) begin
        BRAM_RDATA <= ram[BRAM_ADDRB];
        for (int b = 0; b < 4; b++)
            if (BRAM_WEA[b]) ram[BRAM_ADDRA][8*b +: 8] <= BRAM_WDATA[8*b +: 8];
    end

    function automatic logic [3:0] lanes(input logic [31:0] a, input logic [2:0] sz);
        case (sz)
            3'd0: return 4'b0001 << a[1:0];
            3'd1: return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One bus cycle: address phase of a new transfer overlapping the data phase of the previous one
    task automatic step(input bit v, input bit w, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int waits = 0;
        int ew;
        logic [3:0] ln;
        HSEL = v;
        HTRANS = v ? 2'd2 : 2'd0;
        HADDR = a;
        HWRITE = w;
        HSIZE = sz;
        HWDATA = p_wdata;
        #1;
        while (!HREADYOUT && waits < 8) begin
            @(posedge clka);
            #1;
            waits++;
        end
        if (waits >= 8) chk("ready_timeout", 32'(waits), 32'(p_exp_wait));
        chk("hresp", 32'(HRESP), 32'd0);
        if (p_valid && p_w) begin
            ln = lanes(p_addr, p_size);
            chk("wea", 32'(BRAM_WEA), 32'(ln));
            chk("addra", 32'(BRAM_ADDRA), 32'(widx(p_addr)));
            chk("wdata", BRAM_WDATA, p_wdata);
            for (int b = 0; b < 4; b++)
                if (ln[b]) refm[widx(p_addr)][8*b +: 8] = p_wdata[8*b +: 8];
        end else begin
            chk("wea_off", 32'(BRAM_WEA), 32'd0);
            if (p_valid) begin
                chk("hrdata", HRDATA, refm[widx(p_addr)]);
                chk("waits", 32'(waits), 32'(p_exp_wait));
            end
        end
`ifdef AHB_BRAM_BYPASS_EN
        ew = 0;
`else
        ew = (v && !w && p_valid && p_w && widx(a) == widx(p_addr)) ? 1 : 0;
`endif
        @(posedge clka);
        #1;
        p_valid = v;
        p_w = w;
        p_addr = a;
        p_size = sz;
        p_wdata = wd;
        p_exp_wait = ew;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = $urandom;
            refm[i] = ram[i];
        end
        rst = 1'b1;
        HSEL = 1'b1;
        HTRANS = 2'd2;
        HWRITE = 1'b1;
        HADDR = 32'h40;
        HSIZE = 3'd2;
        HWDATA = 32'hCAFEF00D;
        for (int c = 0; c < 2; c++) begin
            @(posedge clka);
            #1;
            chk("rst_ready", 32'(HREADYOUT), 32'd1);
            chk("rst_wea", 32'(BRAM_WEA), 32'd0);
        end
        rst = 1'b0;
        step(0, 0, 32'h0, 3'd2, 32'h0);
        chk("rst_nowrite", ram[16], refm[16]);

        step(1, 1, 32'h40, 3'd2, 32'hDEADBEEF);
        step(0, 0, 32'h0, 3'd2, 32'h0);
        step(1, 0, 32'h40, 3'd2, 32'h0);
        step(0, 0, 32'h0, 3'd2, 32'h0);
        chk("word_rd", refm[16], 32'hDEADBEEF);

        step(1, 1, 32'h41, 3'd0, 32'h0000AA00);
        step(1, 1, 32'h42, 3'd1, 32'h12340000);
        step(1, 0, 32'h40, 3'd2, 32'h0);
        step(0, 0, 32'h0, 3'd2, 32'h0);
        chk("subword_rd", refm[16], 32'h1234AAEF);

        step(1, 1, 32'h80, 3'd2, 32'h11223344);
        step(1, 1, 32'h83, 3'd0, 32'hFF000000);
        step(1, 0, 32'h80, 3'd2, 32'h0);
        step(0, 0, 32'h0, 3'd2, 32'h0);
        chk("raw_rd", refm[32], 32'hFF223344);

        step(1, 1, 32'h100, 3'd2, 32'h0BADF00D);
        step(1, 0, 32'h104, 3'd2, 32'h0);
        step(0, 0, 32'h0, 3'd2, 32'h0);

        step(1, 1, 32'h10000, 3'd2, 32'h5A5A5A5A);
        step(1, 0, 32'h0, 3'd2, 32'h0);
        step(0, 0, 32'h0, 3'd2, 32'h0);
        chk("wrap_rd", refm[0], 32'h5A5A5A5A);

        for (int n = 0; n < 300; n++)
            step($urandom_range(0, 3) != 0, 1'($urandom), (32'h80 + 32'($urandom_range(0, 15))) | (($urandom % 2) != 0 ? 32'h10000 : 32'h0),
                 3'($urandom_range(0, 3)), $urandom);
        step(0, 0, 32'h0, 3'd2, 32'h0);
        step(0, 0, 32'h0, 3'd2, 32'h0);
        for (int i = 32; i < 36; i++) chk("final_ram", ram[i], refm[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
